// File: rtl/big_core_cr_mem.sv
// Control-register block for the board I/O: 7-seg/LED drive, synchronized buttons and switches, cycle counter.
// Define BIG_CORE_CR_DEBOUNCE_EN to insert per-bit debounce counters after the synchronizers.
module big_core_cr_mem #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic [31:0] data,
   input  logic [31:0] address,
   input  logic        wren,
   input  logic        rden,
   output logic [31:0] q,
   input  logic        Button_0,
   input  logic        Button_1,
   input  logic [9:0]  Switch,
   output logic [7:0]  SEG7_0,
   output logic [7:0]  SEG7_1,
   output logic [7:0]  SEG7_2,
   output logic [7:0]  SEG7_3,
   output logic [7:0]  SEG7_4,
   output logic [7:0]  SEG7_5,
   output logic [9:0]  LED
);

   localparam logic [7:0] OFF_SEG0     = 8'h00;
   localparam logic [7:0] OFF_SEG1     = 8'h04;
   localparam logic [7:0] OFF_SEG2     = 8'h08;
   localparam logic [7:0] OFF_SEG3     = 8'h0C;
   localparam logic [7:0] OFF_SEG4     = 8'h10;
   localparam logic [7:0] OFF_SEG5     = 8'h14;
   localparam logic [7:0] OFF_LED      = 8'h18;
   localparam logic [7:0] OFF_BUTTON_0 = 8'h1C;
   localparam logic [7:0] OFF_BUTTON_1 = 8'h20;
   localparam logic [7:0] OFF_SWITCH   = 8'h24;
   localparam logic [7:0] OFF_CYCLE    = 8'h28;
   localparam logic [7:0] OFF_BTN_EDGE = 8'h2C;

   // Input vector layout: [0]=Button_0, [1]=Button_1, [11:2]=Switch
   logic [11:0] w_raw;
   logic [11:0] r_sync1;
   logic [11:0] r_sync2;
   logic [11:0] w_deb;

   logic [7:0]  r_seg [6];
   logic [9:0]  r_led;
   logic [31:0] r_cycle;
   logic [1:0]  r_btn_edge;
   logic [1:0]  r_btn_prev;
   logic [31:0] r_q;

   logic [7:0]  w_off;
   logic [31:0] w_rdata;
   logic [1:0]  w_btn_rise;
   logic [1:0]  w_btn_clr;
   logic        w_unused;

   assign w_raw    = {Switch, Button_1, Button_0};
   assign w_off    = address[7:0];
   assign w_unused = &{1'b0, address[31:8], data[31:10]};

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
      end
   end

`ifdef BIG_CORE_CR_DEBOUNCE_EN
   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [11:0]   r_deb;
   logic [CW-1:0] r_cnt [12];

   // A bit only follows its synchronized input after DEBOUNCE_CYCLES consecutive differing cycles
   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_deb <= '0;
         for (int i = 0; i < 12; i++) r_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 12; i++) begin
            if (r_sync2[i] == r_deb[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == CNT_LAST) begin
               r_deb[i] <= r_sync2[i];
               r_cnt[i] <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign w_deb = r_deb;
`else
   assign w_deb = r_sync2;
`endif

   assign w_btn_rise = w_deb[1:0] & ~r_btn_prev;
   assign w_btn_clr  = (wren && (w_off == OFF_BTN_EDGE)) ? data[1:0] : 2'b00;

   always_comb begin
      w_rdata = '0;
      case (w_off)
         OFF_SEG0:     w_rdata = {24'b0, r_seg[0]};
         OFF_SEG1:     w_rdata = {24'b0, r_seg[1]};
         OFF_SEG2:     w_rdata = {24'b0, r_seg[2]};
         OFF_SEG3:     w_rdata = {24'b0, r_seg[3]};
         OFF_SEG4:     w_rdata = {24'b0, r_seg[4]};
         OFF_SEG5:     w_rdata = {24'b0, r_seg[5]};
         OFF_LED:      w_rdata = {22'b0, r_led};
         OFF_BUTTON_0: w_rdata = {31'b0, w_deb[0]};
         OFF_BUTTON_1: w_rdata = {31'b0, w_deb[1]};
         OFF_SWITCH:   w_rdata = {22'b0, w_deb[11:2]};
         OFF_CYCLE:    w_rdata = r_cycle;
         OFF_BTN_EDGE: w_rdata = {30'b0, r_btn_edge};
         default:      w_rdata = '0;
      endcase
   end

   // Read data is sampled from current register state, so a same-cycle write is not visible
   always_ff @(posedge Clk) begin
      if (Rst) begin
         for (int i = 0; i < 6; i++) r_seg[i] <= 8'hFF;
         r_led      <= '0;
         r_cycle    <= '0;
         r_btn_edge <= '0;
         r_btn_prev <= '0;
         r_q        <= '0;
      end else begin
         r_cycle    <= r_cycle + 32'd1;
         r_btn_prev <= w_deb[1:0];
         r_btn_edge <= (r_btn_edge & ~w_btn_clr) | w_btn_rise;
         if (rden) r_q <= w_rdata;
         if (wren) begin
            case (w_off)
               OFF_SEG0: r_seg[0] <= data[7:0];
               OFF_SEG1: r_seg[1] <= data[7:0];
               OFF_SEG2: r_seg[2] <= data[7:0];
               OFF_SEG3: r_seg[3] <= data[7:0];
               OFF_SEG4: r_seg[4] <= data[7:0];
               OFF_SEG5: r_seg[5] <= data[7:0];
               OFF_LED:  r_led    <= data[9:0];
               default:  ;
            endcase
         end
      end
   end

   assign q      = r_q;
   assign SEG7_0 = r_seg[0];
   assign SEG7_1 = r_seg[1];
   assign SEG7_2 = r_seg[2];
   assign SEG7_3 = r_seg[3];
   assign SEG7_4 = r_seg[4];
   assign SEG7_5 = r_seg[5];
   assign LED    = r_led;

endmodule

// File: tb/tb_big_core_cr_mem.sv
// Directed bench for big_core_cr_mem; adapts button timing when BIG_CORE_CR_DEBOUNCE_EN is defined.
module tb_big_core_cr_mem;

   localparam int DC = 8;
`ifdef BIG_CORE_CR_DEBOUNCE_EN
   localparam int EDGE_LAT = 2 + DC;
`else
   localparam int EDGE_LAT = 2;
`endif
   localparam int SETTLE = EDGE_LAT + 3;

   logic        Clk;
   logic        Rst;
   logic [31:0] data;
   logic [31:0] address;
   logic        wren;
   logic        rden;
   logic [31:0] q;
   logic        Button_0;
   logic        Button_1;
   logic [9:0]  Switch;
   logic [7:0]  SEG7_0, SEG7_1, SEG7_2, SEG7_3, SEG7_4, SEG7_5;
   logic [9:0]  LED;

   int n_checks = 0;
   int n_errors = 0;

   big_core_cr_mem #(.DEBOUNCE_CYCLES(DC)) dut (
      .Clk(Clk), .Rst(Rst), .data(data), .address(address), .wren(wren), .rden(rden), .q(q),
      .Button_0(Button_0), .Button_1(Button_1), .Switch(Switch),
      .SEG7_0(SEG7_0), .SEG7_1(SEG7_1), .SEG7_2(SEG7_2), .SEG7_3(SEG7_3),
      .SEG7_4(SEG7_4), .SEG7_5(SEG7_5), .LED(LED)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic tick();
      @(posedge Clk);
      @(negedge Clk);
   endtask

   task automatic wait_cycles(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      address = a; data = d; wren = 1'b1;
      tick();
      wren = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a);
      address = a; rden = 1'b1;
      tick();
      rden = 1'b0;
   endtask

   logic [31:0] vals [4];
   logic        saw_zero;

   initial begin
      Rst = 1'b1; data = '0; address = '0; wren = 1'b0; rden = 1'b0;
      Button_0 = 1'b0; Button_1 = 1'b0; Switch = '0;
      wait_cycles(3);

      // Reset values
      check("rst_seg0", {24'b0, SEG7_0}, 32'hFF);
      check("rst_seg1", {24'b0, SEG7_1}, 32'hFF);
      check("rst_seg2", {24'b0, SEG7_2}, 32'hFF);
      check("rst_seg3", {24'b0, SEG7_3}, 32'hFF);
      check("rst_seg4", {24'b0, SEG7_4}, 32'hFF);
      check("rst_seg5", {24'b0, SEG7_5}, 32'hFF);
      check("rst_led", {22'b0, LED}, 32'h0);
      check("rst_q", q, 32'h0);

      // CYCLE starts at 0 on the first cycle after reset and counts up
      Rst = 1'b0; address = 32'h28; rden = 1'b1;
      tick();
      check("cycle_first", q, 32'h0);
      tick();
      check("cycle_second", q, 32'h1);
      rden = 1'b0;

      // LED write/read and q hold
      wr(32'h18, 32'h0000_03A5);
      check("led_write", {22'b0, LED}, 32'h3A5);
      rd(32'h18);
      check("led_read", q, 32'h0000_03A5);
      address = 32'h00;
      tick();
      check("q_hold", q, 32'h0000_03A5);

      // Read-before-write at 0x00
      address = 32'h00; data = 32'h40; wren = 1'b1; rden = 1'b1;
      tick();
      wren = 1'b0; rden = 1'b0;
      check("rbw_q", q, 32'h0000_00FF);
      check("rbw_seg0", {24'b0, SEG7_0}, 32'h40);

      // Upper write bits ignored, read back zero-extended
      wr(32'h14, 32'hFFFF_FF5A);
      check("seg5_write", {24'b0, SEG7_5}, 32'h5A);
      rd(32'h14);
      check("seg5_read", q, 32'h0000_005A);
      wr(32'h19, 32'h0000_03FF);
      check("unaligned_wr_ignored", {22'b0, LED}, 32'h3A5);

      // Switches through the synchronizer
      Switch = 10'h2B5;
      wait_cycles(SETTLE);
      rd(32'h24);
      check("switch_read", q, 32'h0000_02B5);

`ifdef BIG_CORE_CR_DEBOUNCE_EN
      // Short glitch must be filtered out
      Button_0 = 1'b1;
      wait_cycles(5);
      Button_0 = 1'b0;
      wait_cycles(SETTLE);
      rd(32'h1C);
      check("glitch_button0", q, 32'h0);
      rd(32'h2C);
      check("glitch_edge", q, 32'h0);
      Button_0 = 1'b1;
      wait_cycles(30);
`else
      Button_0 = 1'b1;
      wait_cycles(SETTLE);
`endif
      rd(32'h1C);
      check("button0_read", q, 32'h1);
      rd(32'h2C);
      check("edge_b0", q, 32'h1);

      Button_1 = 1'b1;
      wait_cycles(SETTLE);
      rd(32'h20);
      check("button1_read", q, 32'h1);
      rd(32'h2C);
      check("edge_b01", q, 32'h3);

      // W1C of bit 0 only
      wr(32'h2C, 32'h1);
      rd(32'h2C);
      check("w1c_bit0", q, 32'h2);

      // W1C coinciding with a new Button_0 rising edge: set wins
      Button_0 = 1'b0;
      wait_cycles(SETTLE);
      rd(32'h1C);
      check("button0_low", q, 32'h0);
      Button_0 = 1'b1;
      wait_cycles(EDGE_LAT);
      wr(32'h2C, 32'h1);
      rd(32'h2C);
      check("w1c_vs_set", q, 32'h3);

      // CYCLE wrap
      address = 32'h28; rden = 1'b1;
      force dut.r_cycle = 32'hFFFF_FFFE;
      tick();
      check("cycle_forced", q, 32'hFFFF_FFFE);
      release dut.r_cycle;
      saw_zero = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         vals[i] = q;
         if (q === 32'h0) saw_zero = 1'b1;
      end
      rden = 1'b0;
      for (int i = 0; i < 4; i++) check("cycle_no_x", {31'b0, $isunknown(vals[i])}, 32'h0);
      for (int i = 0; i < 3; i++) check("cycle_step", vals[i+1], vals[i] + 32'd1);
      check("cycle_wrapped", {31'b0, saw_zero}, 32'h1);

      // Reset mid-write drops the access
      Button_0 = 1'b0; Button_1 = 1'b0;
      wait_cycles(SETTLE);
      wr(32'h04, 32'h33);
      check("seg1_write", {24'b0, SEG7_1}, 32'h33);
      address = 32'h04; data = 32'h12; wren = 1'b1; rden = 1'b1; Rst = 1'b1;
      tick();
      Rst = 1'b0; wren = 1'b0; rden = 1'b0;
      check("rst_mid_seg1", {24'b0, SEG7_1}, 32'hFF);
      check("rst_mid_q", q, 32'h0);
      check("rst_mid_led", {22'b0, LED}, 32'h0);
      rd(32'h2C);
      check("rst_mid_edge", q, 32'h0);

      // Unmapped offsets read zero
      wr(32'h18, 32'h11);
      rd(32'h18);
      check("led_after_rst", q, 32'h11);
      rd(32'h30);
      check("unmapped_0x30", q, 32'h0);
      rd(32'h18);
      check("led_again", q, 32'h11);
      rd(32'h01);
      check("unmapped_0x01", q, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
